// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code-lock controller.
package lock_pkg;

  localparam int unsigned CODE_W     = 4;
  localparam int unsigned DIGITS_W   = 16;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned FAIL_W     = 2;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    SET_NEW = 2'd2,
    ALARM   = 2'd3
  } lock_state_e;

  localparam logic [CODE_W-1:0] KEY_SET     = 4'hA;
  localparam logic [CODE_W-1:0] KEY_CLEAR   = 4'hE;
  localparam logic [CODE_W-1:0] KEY_CONFIRM = 4'hF;

  function automatic logic is_digit(input logic [CODE_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Key-event input and status/display outputs between keypad side and lock controller.
interface lock_controller_if;
  import lock_pkg::*;

  logic                key_valid;
  logic [CODE_W-1:0]   key_code;
  logic                unlocked;
  logic                alarm;
  logic                set_mode;
  logic [CNT_W-1:0]    entry_cnt;
  logic [DIGITS_W-1:0] entry_digits;
  logic [FAIL_W-1:0]   fail_cnt;

  modport master (
    output key_valid, key_code,
    input  unlocked, alarm, set_mode, entry_cnt, entry_digits, fail_cnt
  );

  modport slave (
    input  key_valid, key_code,
    output unlocked, alarm, set_mode, entry_cnt, entry_digits, fail_cnt
  );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter; expired_o is high during the cycle the count sits at 1
// while enabled, so the consumer leaves on the same edge the count reaches 0.
module lock_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o,
  output logic             expired_o
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             expired_q, expired_d;

  // Expiry is precomputed one edge ahead so it can be a registered pulse.
  always_comb begin
    value_d   = value_q;
    expired_d = 1'b0;
    if (load_i) begin
      value_d   = load_value_i;
      expired_d = (load_value_i == WIDTH'(1));
    end else if (en_i && (value_q != '0)) begin
      value_d   = value_q - WIDTH'(1);
      expired_d = (value_q == WIDTH'(2));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      expired_q <= expired_d;
    end
  end

  assign value_o   = value_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/lock_controller.sv
// Code-lock FSM: digit entry, password compare/change, and timed lockout after
// repeated failed confirms.
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PWD = 16'h1234,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  lock_controller_if.slave bus
);

  localparam int unsigned TIMER_W = $clog2(LOCK_CYCLES + 1);

  lock_state_e         state_q, state_d;
  logic [CNT_W-1:0]    entry_cnt_q, entry_cnt_d;
  logic [DIGITS_W-1:0] entry_q, entry_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [DIGITS_W-1:0] pwd_q, pwd_d;
  logic                unlocked_q, unlocked_d;
  logic                alarm_q, alarm_d;
  logic                set_mode_q, set_mode_d;

  logic                timer_load;
  logic                timer_expired;
  logic [TIMER_W-1:0]  timer_value;

  logic                key_valid;
  logic [CODE_W-1:0]   key_code;
  logic                entry_full;
  logic                accepts_entry;

  assign key_valid     = bus.key_valid;
  assign key_code      = bus.key_code;
  assign entry_full    = (entry_cnt_q == CNT_W'(NUM_DIGITS));
  assign accepts_entry = (state_q == LOCKED) || (state_q == SET_NEW);

  lock_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i (TIMER_W'(LOCK_CYCLES)),
    .en_i         (state_q == ALARM),
    .value_o      (timer_value),
    .expired_o    (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    entry_d     = entry_q;
    fail_d      = fail_q;
    pwd_d       = pwd_q;
    timer_load  = 1'b0;

    // Digit accumulation and CLEAR are shared by both entry states.
    if (accepts_entry && key_valid) begin
      if (is_digit(key_code) && !entry_full) begin
        entry_d     = {entry_q[DIGITS_W-CODE_W-1:0], key_code};
        entry_cnt_d = entry_cnt_q + CNT_W'(1);
      end else if (key_code == KEY_CLEAR) begin
        entry_d     = '0;
        entry_cnt_d = '0;
      end
    end

    case (state_q)
      LOCKED: begin
        if (key_valid && (key_code == KEY_CONFIRM)) begin
          entry_d     = '0;
          entry_cnt_d = '0;
          if (entry_full && (entry_q == pwd_q)) begin
            state_d = OPEN;
            fail_d  = '0;
          end else if ((32'(fail_q) + 32'd1) == MAX_FAIL) begin
            state_d    = ALARM;
            timer_load = 1'b1;
            fail_d     = FAIL_W'(MAX_FAIL);
          end else begin
            fail_d = fail_q + FAIL_W'(1);
          end
        end
      end
      OPEN: begin
        if (key_valid && (key_code == KEY_CONFIRM)) begin
          state_d = LOCKED;
        end else if (key_valid && (key_code == KEY_SET)) begin
          state_d     = SET_NEW;
          entry_d     = '0;
          entry_cnt_d = '0;
        end
      end
      SET_NEW: begin
        if (key_valid && (key_code == KEY_CONFIRM)) begin
          if (entry_full) begin
            pwd_d = entry_q;
          end
          state_d     = OPEN;
          entry_d     = '0;
          entry_cnt_d = '0;
        end
      end
      ALARM: begin
        // Zero-count guard keeps a corrupted timer from trapping the FSM.
        if (timer_expired || (timer_value == '0)) begin
          state_d     = LOCKED;
          fail_d      = '0;
          entry_d     = '0;
          entry_cnt_d = '0;
        end
      end
      default: begin
        state_d = LOCKED;
      end
    endcase

    unlocked_d = (state_d == OPEN) || (state_d == SET_NEW);
    alarm_d    = (state_d == ALARM);
    set_mode_d = (state_d == SET_NEW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOCKED;
      entry_cnt_q <= '0;
      entry_q     <= '0;
      fail_q      <= '0;
      pwd_q       <= DEFAULT_PWD;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
      set_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_cnt_q <= entry_cnt_d;
      entry_q     <= entry_d;
      fail_q      <= fail_d;
      pwd_q       <= pwd_d;
      unlocked_q  <= unlocked_d;
      alarm_q     <= alarm_d;
      set_mode_q  <= set_mode_d;
    end
  end

  assign bus.unlocked     = unlocked_q;
  assign bus.alarm        = alarm_q;
  assign bus.set_mode     = set_mode_q;
  assign bus.entry_cnt    = entry_cnt_q;
  assign bus.entry_digits = entry_q;
  assign bus.fail_cnt     = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed + randomized bench for lock_controller against a queue-based lock model.
module tb_lock_controller;
  import lock_pkg::*;

  localparam int unsigned MAXF  = 3;
  localparam int unsigned LOCKC = 20;

  localparam int M_LOCKED = 0;
  localparam int M_OPEN   = 1;
  localparam int M_SET    = 2;
  localparam int M_ALARM  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lock_controller_if bus ();

  lock_controller #(
    .DEFAULT_PWD (16'h1234),
    .MAX_FAIL    (MAXF),
    .LOCK_CYCLES (LOCKC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the lock as a mode, a list of typed digits and a password list.
  int m_mode;
  int m_entry[$];
  int m_pwd[4];
  int m_fail;
  int m_left;

  function automatic logic [31:0] entry_val();
    logic [31:0] v = 0;
    foreach (m_entry[i]) v = (v << 4) | 32'(m_entry[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("unlocked", 32'(bus.unlocked), 32'(m_mode == M_OPEN || m_mode == M_SET));
    chk("alarm", 32'(bus.alarm), 32'(m_mode == M_ALARM));
    chk("set_mode", 32'(bus.set_mode), 32'(m_mode == M_SET));
    chk("entry_cnt", 32'(bus.entry_cnt), 32'(m_entry.size()));
    chk("entry_digits", 32'(bus.entry_digits), entry_val());
    chk("fail_cnt", 32'(bus.fail_cnt), 32'(m_fail));
  endtask

  task automatic model_reset();
    m_mode = M_LOCKED;
    m_entry.delete();
    m_pwd  = '{1, 2, 3, 4};
    m_fail = 0;
    m_left = 0;
  endtask

  task automatic model_event(input bit v, input int c);
    bit ok;
    if (m_mode == M_ALARM) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = M_LOCKED;
        m_fail = 0;
        m_entry.delete();
      end
      return;
    end
    if (!v) return;
    if (c <= 9) begin
      if ((m_mode == M_LOCKED || m_mode == M_SET) && m_entry.size() < 4) m_entry.push_back(c);
    end else if (c == 14) begin
      if (m_mode == M_LOCKED || m_mode == M_SET) m_entry.delete();
    end else if (c == 10) begin
      if (m_mode == M_OPEN) begin
        m_mode = M_SET;
        m_entry.delete();
      end
    end else if (c == 15) begin
      if (m_mode == M_LOCKED) begin
        ok = (m_entry.size() == 4);
        if (ok) foreach (m_pwd[i]) if (m_entry[i] != m_pwd[i]) ok = 0;
        if (ok) begin
          m_mode = M_OPEN;
          m_fail = 0;
        end else if (m_fail + 1 == int'(MAXF)) begin
          m_mode = M_ALARM;
          m_left = LOCKC;
          m_fail = MAXF;
        end else begin
          m_fail++;
        end
      end else if (m_mode == M_OPEN) begin
        m_mode = M_LOCKED;
      end else if (m_mode == M_SET) begin
        if (m_entry.size() == 4) foreach (m_pwd[i]) m_pwd[i] = m_entry[i];
        m_mode = M_OPEN;
      end
      m_entry.delete();
    end
  endtask

  task automatic step(input bit v, input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = v;
    bus.key_code  = c;
    @(posedge clk);
    model_event(v, int'(c));
    #1;
    check_outputs();
  endtask

  task automatic press_hex(input logic [63:0] codes, input int n);
    for (int i = 0; i < n; i++) step(1'b1, codes[4*(n-1-i) +: 4]);
  endtask

  task automatic press_pwd();
    int p[4];
    p = m_pwd;
    for (int i = 0; i < 4; i++) step(1'b1, 4'(p[i]));
    step(1'b1, 4'hF);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  int cnt;

  initial begin
    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    model_reset();
    #1;
    check_outputs();
    do_reset();

    // Correct entry, then relock.
    press_hex(64'h1234F, 5);
    chk("open_after_1234", 32'(bus.unlocked), 32'd1);
    step(1'b1, 4'hF);
    chk("relock", 32'(bus.unlocked), 32'd0);

    // Editing: clear, then overflow digit ignored.
    press_hex(64'h56E12349, 8);
    chk("edit_digits", 32'(bus.entry_digits), 32'h1234);
    step(1'b1, 4'hF);
    chk("edit_open", 32'(bus.unlocked), 32'd1);
    step(1'b1, 4'hF);

    // Lockout.
    press_hex(64'h1111F, 5);
    chk("fail_1", 32'(bus.fail_cnt), 32'd1);
    press_hex(64'h1111F, 5);
    chk("fail_2", 32'(bus.fail_cnt), 32'd2);
    press_hex(64'h1111F, 5);
    cnt = bus.alarm ? 1 : 0;
    for (int i = 0; i < 100 && bus.alarm; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)));
      if (bus.alarm) cnt++;
    end
    chk("alarm_len", 32'(cnt), LOCKC);
    chk("alarm_fail_clr", 32'(bus.fail_cnt), 32'd0);

    // Password change to 9876.
    press_hex(64'h1234F, 5);
    press_hex(64'hA9876F, 6);
    chk("set_commit_open", 32'(bus.unlocked), 32'd1);
    step(1'b1, 4'hF);
    press_hex(64'h1234F, 5);
    chk("old_pwd_fails", 32'(bus.fail_cnt), 32'd1);
    press_hex(64'h9876F, 5);
    chk("new_pwd_opens", 32'(bus.unlocked), 32'd1);
    step(1'b1, 4'hF);

    // Short commit keeps password; short confirm is a failure.
    do_reset();
    press_hex(64'h1234F, 5);
    press_hex(64'hA5F, 3);
    step(1'b1, 4'hF);
    press_hex(64'h123F, 4);
    chk("short_fail", 32'(bus.fail_cnt), 32'd1);
    press_hex(64'h1234F, 5);
    chk("short_commit_kept", 32'(bus.unlocked), 32'd1);
    step(1'b1, 4'hF);

    // Reset mid-ALARM.
    for (int k = 0; k < 3; k++) press_hex(64'hF, 1);
    step(1'b0, 4'h0);
    do_reset();
    chk("rst_alarm_clr", 32'(bus.alarm), 32'd0);
    press_hex(64'h1234F, 5);
    chk("rst_alarm_default", 32'(bus.unlocked), 32'd1);

    // Reset mid-SET_NEW loses the pending change.
    press_hex(64'hA9876, 5);
    do_reset();
    press_hex(64'h1234F, 5);
    chk("rst_set_default", 32'(bus.unlocked), 32'd1);
    step(1'b1, 4'hF);

    // Random traffic with occasional correct codes and resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0) do_reset();
      else if (r < 8) press_pwd();
      else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
